qed_decode_stage: RTL

- Registered, parametrised QED decode stage between instruction fetch and the core's decode logic.
- Splits each accepted instruction into its fields and a one-hot opcode class. All input and output transfers use valid/ready handshakes.
- In QED (EDDI-V) mode it emits every duplicable instruction twice: first the original, then a duplicate. In the duplicate, register fields are remapped into the upper half of the register file.
- Keeps wrapping counts of emitted originals and duplicates for the QED consistency checker.

---
 rtl/qed_pkg.sv | 64 ++++++
 rtl/qed_field_decode.sv | 59 +++++
 rtl/qed_decode_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/qed_pkg.sv
// qed_pkg: shared definitions for the QED decode stage.
//   - RV32 base opcode constants
//   - class indices for the one-hot out_class vector
//   - register-field bit positions in an RV32 instruction word
//   - FSM state type for the decode stage
//   - qed_remap_reg(): maps a register index into the duplicate half
package qed_pkg;

    // RV32 base opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Bit index of each class inside out_class (bit 0 = R).
    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LW     = 4'd2,
        CLS_SW     = 4'd3,
        CLS_B      = 4'd4,
        CLS_J      = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_FENCE  = 4'd8,
        CLS_SYSTEM = 4'd9
    } qed_class_e;

    localparam int NUM_CLASSES = 10;

    // Classes that may be duplicated: everything except control flow,
    // FENCE and SYSTEM.
    localparam logic [NUM_CLASSES-1:0] DUP_CLASS_MASK = 10'b00_1100_1111;

    // RV32 register-field positions and width
    localparam int REG_FIELD_W = 5;
    localparam int RD_LSB      = 7;
    localparam int RS1_LSB     = 15;
    localparam int RS2_LSB     = 20;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ORIG  = 2'd1,
        ST_DUP   = 2'd2
    } qed_state_e;

    // Set the MSB of a reg_aw-bit register index; x0 stays x0.
    function automatic logic [REG_FIELD_W-1:0] qed_remap_reg(
        input logic [REG_FIELD_W-1:0] r,
        input int unsigned            reg_aw
    );
        logic [REG_FIELD_W-1:0] msb;
        msb = REG_FIELD_W'(1) << (reg_aw - 1);
        return (r == '0) ? r : (r | msb);
    endfunction

endpackage

// File: rtl/qed_field_decode.sv
// qed_field_decode: purely combinational RV32 field slicer and opcode
// classifier.
//   instr   in   ILEN    instruction word
//   opcode  out  7       [6:0]
//   rd      out  REG_AW  [7 +: REG_AW]
//   rs1     out  REG_AW  [15 +: REG_AW]
//   rs2     out  REG_AW  [20 +: REG_AW]
//   funct3  out  3       [14:12]
//   funct7  out  7       [31:25]
//   imm12   out  12      [31:20]
//   uimm    out  20      [31:12]
//   cls     out  10      one-hot class, all zero for unknown opcodes
module qed_field_decode
    import qed_pkg::*;
#(
    parameter int ILEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [ILEN-1:0]        instr,
    output logic [6:0]             opcode,
    output logic [REG_AW-1:0]      rd,
    output logic [REG_AW-1:0]      rs1,
    output logic [REG_AW-1:0]      rs2,
    output logic [2:0]             funct3,
    output logic [6:0]             funct7,
    output logic [11:0]            imm12,
    output logic [19:0]            uimm,
    output logic [NUM_CLASSES-1:0] cls
);

    assign opcode = instr[6:0];
    assign rd     = instr[RD_LSB  +: REG_AW];
    assign rs1    = instr[RS1_LSB +: REG_AW];
    assign rs2    = instr[RS2_LSB +: REG_AW];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm12  = instr[31:20];
    assign uimm   = instr[31:12];

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_REG:    cls[CLS_R]      = 1'b1;
            OPC_IMM:    cls[CLS_I]      = 1'b1;
            OPC_LOAD:   cls[CLS_LW]     = 1'b1;
            OPC_STORE:  cls[CLS_SW]     = 1'b1;
            OPC_BRANCH: cls[CLS_B]      = 1'b1;
            // JALR is a jump too; it must never be duplicated.
            OPC_JAL,
            OPC_JALR:   cls[CLS_J]      = 1'b1;
            OPC_LUI:    cls[CLS_LUI]    = 1'b1;
            OPC_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
            OPC_FENCE:  cls[CLS_FENCE]  = 1'b1;
            OPC_SYSTEM: cls[CLS_SYSTEM] = 1'b1;
            default:    cls = '0;
        endcase
    end

endmodule

// File: rtl/qed_decode_stage.sv
// qed_decode_stage: registered decode stage with QED (EDDI-V) duplication.
// Holds one instruction, presents its decoded fields downstream and, in QED
// mode, re-presents duplicable instructions a second time with register
// fields moved into the upper half of the register file.
//   clk, rst_n                  clock / asynchronous active-low reset
//   qed_mode                    duplicate mode, sampled at accept
//   in_valid/in_ready/in_instr  fetch-side handshake
//   out_valid/out_ready         decode-side handshake
//   out_instr, out_opcode, out_rd/rs1/rs2, out_funct3/7, out_imm12, out_uimm,
//   out_class                   decoded view of the presented instruction
//   out_is_dup                  presented copy is the duplicate
//   out_qed_err                 original already uses the duplicate half
//   orig_cnt / dup_cnt          wrapping emission counters
module qed_decode_stage
    import qed_pkg::*;
#(
    parameter int ILEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   qed_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ILEN-1:0]        in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ILEN-1:0]        out_instr,
    output logic [6:0]             out_opcode,
    output logic [REG_AW-1:0]      out_rd,
    output logic [REG_AW-1:0]      out_rs1,
    output logic [REG_AW-1:0]      out_rs2,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_funct7,
    output logic [11:0]            out_imm12,
    output logic [19:0]            out_uimm,
    output logic [NUM_CLASSES-1:0] out_class,
    output logic                   out_is_dup,
    output logic                   out_qed_err,
    output logic [CNT_W-1:0]       orig_cnt,
    output logic [CNT_W-1:0]       dup_cnt
);

    qed_state_e        state_reg, state_next;
    logic [ILEN-1:0]   instr_reg, instr_next;
    logic              qed_mode_reg, qed_mode_next;
    logic [CNT_W-1:0]  orig_cnt_reg, dup_cnt_reg;

    // ------------------------------------------------------------------
    // Field decode of the held word (original or, in DUP, the remapped one)
    // ------------------------------------------------------------------
    qed_field_decode #(
        .ILEN   (ILEN),
        .REG_AW (REG_AW)
    ) u_field_decode (
        .instr  (instr_reg),
        .opcode (out_opcode),
        .rd     (out_rd),
        .rs1    (out_rs1),
        .rs2    (out_rs2),
        .funct3 (out_funct3),
        .funct7 (out_funct7),
        .imm12  (out_imm12),
        .uimm   (out_uimm),
        .cls    (out_class)
    );

    // ------------------------------------------------------------------
    // Remap. Only fields that really are registers for the class are
    // touched, so immediate bits sharing those positions (I/U-type) stay
    // intact. Index 0 = rd, 1 = rs1, 2 = rs2.
    // ------------------------------------------------------------------
    logic [2:0]        field_use;
    logic [2:0]        field_hi;
    logic [REG_AW-1:0] field_val [3];
    logic [REG_AW-1:0] field_dup [3];

    assign field_use[0] = out_class[CLS_R] | out_class[CLS_I] | out_class[CLS_LW]
                        | out_class[CLS_LUI] | out_class[CLS_AUIPC];
    assign field_use[1] = out_class[CLS_R] | out_class[CLS_I] | out_class[CLS_LW]
                        | out_class[CLS_SW];
    assign field_use[2] = out_class[CLS_R] | out_class[CLS_SW];

    assign field_val[0] = out_rd;
    assign field_val[1] = out_rs1;
    assign field_val[2] = out_rs2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            assign field_hi[gi]  = field_use[gi] & field_val[gi][REG_AW-1];
            assign field_dup[gi] = field_use[gi]
                ? REG_AW'(qed_remap_reg(REG_FIELD_W'(field_val[gi]), REG_AW))
                : field_val[gi];
        end
    endgenerate

    logic [ILEN-1:0] instr_dup;

    always_comb begin
        instr_dup                          = instr_reg;
        instr_dup[RD_LSB  +: REG_AW]       = field_dup[0];
        instr_dup[RS1_LSB +: REG_AW]       = field_dup[1];
        instr_dup[RS2_LSB +: REG_AW]       = field_dup[2];
    end

    // ------------------------------------------------------------------
    // Handshake and emission decisions
    // ------------------------------------------------------------------
    logic duplicable;
    logic qed_conflict;
    logic emit_dup;
    logic last_emit;
    logic accept;

    assign duplicable   = qed_mode_reg && |(out_class & DUP_CLASS_MASK);
    // An original already in the duplicate half cannot be remapped without
    // aliasing, so it is flagged and emitted only once.
    assign qed_conflict = |field_hi;
    assign emit_dup     = duplicable && !qed_conflict;

    assign last_emit = ((state_reg == ST_ORIG) && !emit_dup) || (state_reg == ST_DUP);
    assign in_ready  = (state_reg == ST_EMPTY) || (out_ready && last_emit);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next    = state_reg;
        instr_next    = instr_reg;
        qed_mode_next = qed_mode_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next    = ST_ORIG;
                    instr_next    = in_instr;
                    qed_mode_next = qed_mode;
                end
            end
            ST_ORIG: begin
                if (out_ready) begin
                    if (emit_dup) begin
                        state_next = ST_DUP;
                        instr_next = instr_dup;
                    end else if (accept) begin
                        state_next    = ST_ORIG;
                        instr_next    = in_instr;
                        qed_mode_next = qed_mode;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            ST_DUP: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next    = ST_ORIG;
                        instr_next    = in_instr;
                        qed_mode_next = qed_mode;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            instr_reg    <= '0;
            qed_mode_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            instr_reg    <= instr_next;
            qed_mode_reg <= qed_mode_next;
        end
    end

    // ------------------------------------------------------------------
    // Emission counters (wrap naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig_cnt_reg <= '0;
            dup_cnt_reg  <= '0;
        end else begin
            if ((state_reg == ST_ORIG) && out_ready)
                orig_cnt_reg <= orig_cnt_reg + 1'b1;
            if ((state_reg == ST_DUP) && out_ready)
                dup_cnt_reg <= dup_cnt_reg + 1'b1;
        end
    end

    assign out_valid   = (state_reg != ST_EMPTY);
    assign out_is_dup  = (state_reg == ST_DUP);
    assign out_qed_err = (state_reg == ST_ORIG) && duplicable && qed_conflict;
    assign out_instr   = instr_reg;
    assign orig_cnt    = orig_cnt_reg;
    assign dup_cnt     = dup_cnt_reg;

endmodule
